bloom_bucket_sched: RTL and testbench

Rotation scheduler for the time-bucketed Bloom filter. Consumes the periodic `update` pulse from the watchdog timer, advances the current insert bucket, and sweeps the oldest bucket to zero through the single shared filter-memory write port. Arbitrates that port between the clear sweep and datapath insert writes, with a starvation guard for the sweep. Publishes which buckets are valid for lookups.

---
 rtl/bloom_sched_pkg.sv | 30 +++
 rtl/bucket_clear_sweeper.sv | 40 ++++
 rtl/bloom_bucket_sched.sv | 219 +++++++++++++++++++++
 tb/tb_bloom_bucket_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_sched_pkg.sv
// Shared definitions for the Bloom filter bucket rotation scheduler:
// scheduler state encoding and the bit-width helpers used to size indices.
package bloom_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Ceiling log2 of a positive integer (1 -> 0, 4 -> 2, 5 -> 3).
    function automatic int clog2_int(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Index width for a count of items, never narrower than one bit.
    // BW for the bucket index is bucket_bits(NUM_BUCKETS).
    function automatic int bucket_bits(input int count);
        return (clog2_int(count) < 1) ? 1 : clog2_int(count);
    endfunction

endpackage

// File: rtl/bucket_clear_sweeper.sv
// Row address counter for the bucket clear sweep. 'start' rewinds to row 0,
// 'advance' steps one row (wrapping naturally past the last row), and 'last'
// flags that the current row is the final row of a bucket.
module bucket_clear_sweeper #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Next row: a restart takes priority over stepping.
    always_comb begin
        addr_d = addr_q;
        if (start) begin
            addr_d = '0;
        end else if (advance) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    // Row register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = &addr_q;

endmodule

// File: rtl/bloom_bucket_sched.sv
// Rotation scheduler for the time-bucketed Bloom filter. Owns the single
// filter-memory write port: the zero sweep of the oldest bucket and datapath
// inserts share it, with a stall counter that guarantees sweep progress.
//
// Datapath handshake: dp_req is a request that is held with dp_addr/dp_data
// stable; the write is accepted in exactly the cycles where dp_grant is high
// (dp_grant is combinational from state, stall count and dp_req only), and
// the accepted write appears on mem_wr_* one cycle later.
module bloom_bucket_sched
    import bloom_sched_pkg::*;
#(
    parameter int NUM_BUCKETS = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int STALL_LIMIT = 8,
    localparam int BW = bucket_bits(NUM_BUCKETS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   update,
    input  logic                   dp_req,
    input  logic [ADDR_WIDTH-1:0]  dp_addr,
    input  logic [DATA_WIDTH-1:0]  dp_data,
    output logic                   dp_grant,
    output logic                   mem_wr_en,
    output logic [BW-1:0]          mem_wr_bucket,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [DATA_WIDTH-1:0]  mem_wr_data,
    output logic [BW-1:0]          cur_bucket,
    output logic [NUM_BUCKETS-1:0] valid_mask,
    output logic                   ready,
    output logic                   clearing,
    output logic                   overrun,
    output logic [1:0]             dbg_state
);

    localparam int SW = bucket_bits(STALL_LIMIT + 1);

    state_e                 state_q, state_d;
    logic [BW-1:0]          cur_q, cur_d;
    logic [BW-1:0]          sweep_bucket_q, sweep_bucket_d;
    logic [NUM_BUCKETS-1:0] valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic                   pending_q, pending_d;
    logic [SW-1:0]          stall_q, stall_d;
    logic                   overrun_q, overrun_d;
    logic                   wr_en_q, wr_en_d;
    logic [BW-1:0]          wr_bucket_q, wr_bucket_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

    logic                   upd;
    logic                   sweep_grant;
    logic                   grant_dp;
    logic                   sweep_start;
    logic                   sweep_advance;
    logic                   rotate;
    logic                   consume;
    logic                   upd_direct;
    logic [ADDR_WIDTH-1:0]  sweep_addr;
    logic                   sweep_last;

    function automatic logic [BW-1:0] next_bucket(input logic [BW-1:0] b);
        return (b == BW'(NUM_BUCKETS - 1)) ? '0 : b + BW'(1);
    endfunction

    bucket_clear_sweeper #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweeper (
        .clk     (clk),
        .reset   (reset),
        .start   (sweep_start),
        .advance (sweep_advance),
        .addr    (sweep_addr),
        .last    (sweep_last)
    );

    assign upd = update & enable;

    // Next state, port arbitration, rotation and pending-update bookkeeping.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        sweep_bucket_d = sweep_bucket_q;
        valid_d        = valid_q;
        ready_d        = ready_q;
        pending_d      = pending_q;
        stall_d        = '0;
        overrun_d      = 1'b0;
        sweep_grant    = 1'b0;
        grant_dp       = 1'b0;
        sweep_start    = 1'b0;
        sweep_advance  = 1'b0;
        rotate         = 1'b0;
        consume        = 1'b0;
        upd_direct     = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Bucket-major wipe of the whole memory, datapath locked out.
                sweep_grant   = 1'b1;
                sweep_advance = 1'b1;
                if (sweep_last) begin
                    if (sweep_bucket_q == BW'(NUM_BUCKETS - 1)) begin
                        state_d        = ST_IDLE;
                        valid_d        = '1;
                        ready_d        = 1'b1;
                        cur_d          = '0;
                        sweep_bucket_d = '0;
                    end else begin
                        sweep_bucket_d = next_bucket(sweep_bucket_q);
                    end
                end
            end
            ST_IDLE: begin
                grant_dp = dp_req;
                if (pending_q) begin
                    rotate  = 1'b1;
                    consume = 1'b1;
                end else if (upd) begin
                    rotate     = 1'b1;
                    upd_direct = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Datapath wins until the sweep has been denied STALL_LIMIT times.
                if (dp_req && (stall_q != SW'(STALL_LIMIT))) begin
                    grant_dp = 1'b1;
                    stall_d  = stall_q + SW'(1);
                end else begin
                    sweep_grant   = 1'b1;
                    sweep_advance = 1'b1;
                end
                if (sweep_grant && sweep_last) begin
                    valid_d[sweep_bucket_q] = 1'b1;
                    if (pending_q) begin
                        rotate  = 1'b1;
                        consume = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A rotation advances the insert bucket and retires the one after it.
        if (rotate) begin
            cur_d                   = next_bucket(cur_q);
            sweep_bucket_d          = next_bucket(cur_d);
            valid_d[sweep_bucket_d] = 1'b0;
            sweep_start             = 1'b1;
            state_d                 = ST_CLEAR;
        end

        // Updates that cannot rotate right now are held one deep.
        if (upd && !upd_direct) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else if (consume) begin
            pending_d = 1'b0;
        end

        wr_en_d     = sweep_grant | grant_dp;
        wr_bucket_d = sweep_grant ? sweep_bucket_q : cur_q;
        wr_addr_d   = sweep_grant ? sweep_addr : dp_addr;
        wr_data_d   = sweep_grant ? '0 : dp_data;
    end

    // State and output registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            cur_q          <= '0;
            sweep_bucket_q <= '0;
            valid_q        <= '0;
            ready_q        <= 1'b0;
            pending_q      <= 1'b0;
            stall_q        <= '0;
            overrun_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_bucket_q    <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            sweep_bucket_q <= sweep_bucket_d;
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            pending_q      <= pending_d;
            stall_q        <= stall_d;
            overrun_q      <= overrun_d;
            wr_en_q        <= wr_en_d;
            wr_bucket_q    <= wr_bucket_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign dp_grant      = grant_dp;
    assign mem_wr_en     = wr_en_q;
    assign mem_wr_bucket = wr_bucket_q;
    assign mem_wr_addr   = wr_addr_q;
    assign mem_wr_data   = wr_data_q;
    assign cur_bucket    = cur_q;
    assign valid_mask    = valid_q;
    assign ready         = ready_q;
    assign clearing      = (state_q != ST_IDLE);
    assign overrun       = overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_bloom_bucket_sched.sv
// Directed bench for bloom_bucket_sched (NUM_BUCKETS=4, ADDR_WIDTH=3,
// STALL_LIMIT=2). Expected memory writes are queued ahead of each scenario
// and matched in order as mem_wr_en strobes appear.
module tb_bloom_bucket_sched;

    localparam int NB   = 4;
    localparam int AW   = 3;
    localparam int DW   = 32;
    localparam int BW   = 2;
    localparam int SL   = 2;
    localparam int ROWS = 8;
    localparam int W    = BW + AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          update;
    logic          dp_req;
    logic [AW-1:0] dp_addr;
    logic [DW-1:0] dp_data;
    logic          dp_grant;
    logic          mem_wr_en;
    logic [BW-1:0] mem_wr_bucket;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [BW-1:0] cur_bucket;
    logic [NB-1:0] valid_mask;
    logic          ready;
    logic          clearing;
    logic          overrun;
    logic [1:0]    dbg_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_writes  = 0;
    int n_overrun = 0;
    logic [W-1:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    bloom_bucket_sched #(
        .NUM_BUCKETS (NB),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STALL_LIMIT (SL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .update        (update),
        .dp_req        (dp_req),
        .dp_addr       (dp_addr),
        .dp_data       (dp_data),
        .dp_grant      (dp_grant),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_bucket (mem_wr_bucket),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .cur_bucket    (cur_bucket),
        .valid_mask    (valid_mask),
        .ready         (ready),
        .clearing      (clearing),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] wr(input int b, input int a, input logic [DW-1:0] d);
        logic [BW-1:0] bb;
        logic [AW-1:0] aa;
        bb = BW'(b);
        aa = AW'(a);
        return {bb, aa, d};
    endfunction

    // One clock; sample registered outputs 1ns after the edge and score writes.
    task automatic step_mon();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (overrun) n_overrun++;
        if (mem_wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(mem_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr", 64'({mem_wr_bucket, mem_wr_addr, mem_wr_data}), 64'(e));
            end
        end
    endtask

    task automatic push_sweep(input int b);
        for (int r = 0; r < ROWS; r++) exp_q.push_back(wr(b, r, '0));
    endtask

    task automatic check_reset_values();
        chk("rst_cur", 64'(cur_bucket), 64'd0);
        chk("rst_valid", 64'(valid_mask), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_clearing", 64'(clearing), 64'd1);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
    endtask

    // Reset, then run the full INIT wipe (32 consecutive writes).
    task automatic do_reset(input bit detail);
        reset   = 1'b1;
        update  = 1'b0;
        dp_req  = 1'b0;
        enable  = 1'b1;
        n_writes = 0;
        step_mon();
        step_mon();
        if (detail) check_reset_values();
        reset = 1'b0;
        for (int b = 0; b < NB; b++) push_sweep(b);
        dp_req = detail;
        for (int i = 1; i <= NB * ROWS; i++) begin
            step_mon();
            if (detail) begin
                if (i < NB * ROWS) chk("init_dp_grant", 64'(dp_grant), 64'd0);
                if (i == NB * ROWS - 1) chk("init_ready_early", 64'(ready), 64'd0);
            end
        end
        dp_req = 1'b0;
        chk("init_writes", 64'(n_writes), 64'(NB * ROWS));
        chk("init_ready", 64'(ready), 64'd1);
        chk("init_valid", 64'(valid_mask), 64'hF);
        if (detail) begin
            chk("init_cur", 64'(cur_bucket), 64'd0);
            chk("init_clearing", 64'(clearing), 64'd0);
            chk("init_state", 64'(dbg_state), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit mid_done;
        int exp_cur;
        int tgt;
        logic [NB-1:0] exp_valid;

        reset   = 1'b1;
        enable  = 1'b1;
        update  = 1'b0;
        dp_req  = 1'b0;
        dp_addr = '0;
        dp_data = 32'h1234_5678;

        // Scenario 1: reset values and the initial wipe.
        do_reset(1'b1);

        // Scenario 2: single rotation with no datapath traffic.
        update = 1'b1;
        step_mon();
        update = 1'b0;
        chk("rot_cur", 64'(cur_bucket), 64'd1);
        chk("rot_valid", 64'(valid_mask), 64'hB);
        chk("rot_clearing", 64'(clearing), 64'd1);
        chk("rot_state", 64'(dbg_state), 64'd2);
        push_sweep(2);
        repeat (ROWS) step_mon();
        chk("rot_done_q", 64'(exp_q.size()), 64'd0);
        chk("rot_done_valid", 64'(valid_mask), 64'hF);
        chk("rot_done_clearing", 64'(clearing), 64'd0);
        step_mon();

        // Scenario 2b: update with enable low does nothing.
        enable = 1'b0;
        update = 1'b1;
        n_overrun = 0;
        step_mon();
        update = 1'b0;
        enable = 1'b1;
        step_mon();
        chk("dis_cur", 64'(cur_bucket), 64'd1);
        chk("dis_clearing", 64'(clearing), 64'd0);
        chk("dis_overrun", 64'(n_overrun), 64'd0);

        // Scenario 3: sweep contending with continuous datapath writes.
        do_reset(1'b0);
        dp_addr = 3'd5;
        dp_data = 32'hCAFE_0005;
        update  = 1'b1;
        step_mon();
        update  = 1'b0;
        dp_req  = 1'b1;
        chk("cont_cur", 64'(cur_bucket), 64'd1);
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back(wr(1, 5, 32'hCAFE_0005));
            exp_q.push_back(wr(1, 5, 32'hCAFE_0005));
            exp_q.push_back(wr(2, r, '0));
        end
        n_writes = 0;
        repeat (3 * ROWS) step_mon();
        dp_req = 1'b0;
        chk("cont_writes", 64'(n_writes), 64'(3 * ROWS));
        chk("cont_q", 64'(exp_q.size()), 64'd0);
        chk("cont_valid", 64'(valid_mask), 64'hF);
        chk("cont_clearing", 64'(clearing), 64'd0);
        step_mon();

        // Scenario 4: pending rotation and a dropped update.
        do_reset(1'b0);
        n_overrun = 0;
        n_writes  = 0;
        mid_done  = 1'b0;
        push_sweep(2);
        push_sweep(3);
        for (int k = 0; k < 20; k++) begin
            update = (k == 0) || (k == 2) || (k == 4);
            step_mon();
            update = 1'b0;
            if (n_writes == ROWS && !mid_done) begin
                mid_done = 1'b1;
                chk("pend_mid_cur", 64'(cur_bucket), 64'd2);
                chk("pend_mid_valid", 64'(valid_mask), 64'h7);
                chk("pend_mid_clearing", 64'(clearing), 64'd1);
            end
        end
        chk("pend_mid_seen", 64'(mid_done), 64'd1);
        chk("pend_q", 64'(exp_q.size()), 64'd0);
        chk("pend_overrun", 64'(n_overrun), 64'd1);
        chk("pend_cur", 64'(cur_bucket), 64'd2);
        chk("pend_valid", 64'(valid_mask), 64'hF);
        chk("pend_clearing", 64'(clearing), 64'd0);

        // Scenario 5: four rotations, wrapping the bucket indices.
        do_reset(1'b0);
        for (int r = 0; r < NB; r++) begin
            exp_cur   = (r + 1) % NB;
            tgt       = (r + 2) % NB;
            exp_valid = 4'hF;
            exp_valid[tgt] = 1'b0;
            update = 1'b1;
            step_mon();
            update = 1'b0;
            chk("wrap_cur", 64'(cur_bucket), 64'(exp_cur));
            chk("wrap_valid_clr", 64'(valid_mask), 64'(exp_valid));
            push_sweep(tgt);
            repeat (ROWS) step_mon();
            chk("wrap_q", 64'(exp_q.size()), 64'd0);
            chk("wrap_valid_set", 64'(valid_mask), 64'hF);
        end

        // Scenario 6: reset in the middle of a sweep restarts INIT.
        update = 1'b1;
        step_mon();
        update = 1'b0;
        chk("abort_cur", 64'(cur_bucket), 64'd1);
        for (int r = 0; r < 4; r++) exp_q.push_back(wr(2, r, '0));
        repeat (4) step_mon();
        chk("abort_pre_q", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        step_mon();
        reset = 1'b0;
        check_reset_values();
        n_writes = 0;
        for (int b = 0; b < NB; b++) push_sweep(b);
        step_mon();
        chk("abort_first_wr", 64'(n_writes), 64'd1);
        chk("abort_first_valid", 64'(valid_mask), 64'd0);
        chk("abort_first_ready", 64'(ready), 64'd0);
        repeat (NB * ROWS - 1) step_mon();
        chk("abort_init_q", 64'(exp_q.size()), 64'd0);
        chk("abort_init_ready", 64'(ready), 64'd1);
        chk("abort_init_valid", 64'(valid_mask), 64'hF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
